// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register stage that feeds the 32-bit adder/subtractor.
//
// The stage holds one decoded instruction. It chooses the A operand (rs1 or PC)
// and the B operand (rs2 or immediate). While an entry is held, it forwards
// results from EX/MEM and MEM/WB into rs1 and rs2. When a load-use hazard
// occurs, it inserts a one-cycle bubble.
//
// Build option: EX_OPERAND_STALL_CNT_EN
//   defined   -> stall_cnt counts the cycles in which in_valid & ~in_ready
//   undefined -> stall_cnt is tied to 0
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    decode handshake
//   in_rs*_data/addr/used, in_imm, in_pc, in_use_pc, in_use_imm,
//   in_sub, in_is_load, in_rd
//                        decoded instruction fields
//   flush                synchronous kill of the held entry
//   out_valid/out_ready  AU-side handshake
//   au_a, au_b, au_cin   AU operands; B is raw because the AU inverts it on Cin
//   out_rd, out_is_load  registered destination register and load flag
//   exm_*, wb_*          forwarding sources (EX/MEM has priority)
//   stall_cnt            stall cycle counter
module ex_operand_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RADDR = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_rs1_data,
    input  logic [WIDTH-1:0] in_rs2_data,
    input  logic [RADDR-1:0] in_rs1_addr,
    input  logic [RADDR-1:0] in_rs2_addr,
    input  logic             in_rs1_used,
    input  logic             in_rs2_used,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [WIDTH-1:0] in_pc,
    input  logic             in_use_pc,
    input  logic             in_use_imm,
    input  logic             in_sub,
    input  logic             in_is_load,
    input  logic [RADDR-1:0] in_rd,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    output logic             au_cin,
    output logic [RADDR-1:0] out_rd,
    output logic             out_is_load,
    input  logic             exm_we,
    input  logic [RADDR-1:0] exm_rd,
    input  logic [WIDTH-1:0] exm_data,
    input  logic             wb_we,
    input  logic [RADDR-1:0] wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    output logic [31:0]      stall_cnt
);

    logic             valid_q;
    logic [WIDTH-1:0] rs1_data_q;
    logic [WIDTH-1:0] rs2_data_q;
    logic [RADDR-1:0] rs1_addr_q;
    logic [RADDR-1:0] rs2_addr_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] pc_q;
    logic             use_pc_q;
    logic             use_imm_q;
    logic             sub_q;
    logic             is_load_q;
    logic [RADDR-1:0] rd_q;

    logic             hazard;
    logic             accept;
    logic [WIDTH-1:0] fwd_rs1;
    logic [WIDTH-1:0] fwd_rs2;

    // A held load's result is not ready yet, so a dependent instruction must wait.
    always_comb begin
        hazard = 1'b0;
        if (in_valid && valid_q && is_load_q && (rd_q != '0)) begin
            hazard = (in_rs1_used && (in_rs1_addr == rd_q)) ||
                     (in_rs2_used && (in_rs2_addr == rd_q));
        end
    end

    assign in_ready = (~valid_q | out_ready) & ~hazard;
    // A flush in the same cycle drops the accept even though in_ready may be high.
    assign accept   = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
        end else if (out_ready && valid_q) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            use_pc_q   <= 1'b0;
            use_imm_q  <= 1'b0;
            sub_q      <= 1'b0;
            is_load_q  <= 1'b0;
            rd_q       <= '0;
        end else if (accept) begin
            rs1_data_q <= in_rs1_data;
            rs2_data_q <= in_rs2_data;
            rs1_addr_q <= in_rs1_addr;
            rs2_addr_q <= in_rs2_addr;
            imm_q      <= in_imm;
            pc_q       <= in_pc;
            use_pc_q   <= in_use_pc;
            use_imm_q  <= in_use_imm;
            sub_q      <= in_sub;
            is_load_q  <= in_is_load;
            rd_q       <= in_rd;
        end
    end

    // Forwarding is re-evaluated every cycle so a stalled entry picks up late results.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (exm_we && (exm_rd != '0) && (exm_rd == rs1_addr_q)) begin
            fwd_rs1 = exm_data;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == rs1_addr_q)) begin
            fwd_rs1 = wb_data;
        end
    end

    always_comb begin
        fwd_rs2 = rs2_data_q;
        if (exm_we && (exm_rd != '0) && (exm_rd == rs2_addr_q)) begin
            fwd_rs2 = exm_data;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == rs2_addr_q)) begin
            fwd_rs2 = wb_data;
        end
    end

    assign au_a        = use_pc_q  ? pc_q  : fwd_rs1;
    assign au_b        = use_imm_q ? imm_q : fwd_rs2;
    assign au_cin      = sub_q;
    assign out_valid   = valid_q;
    assign out_rd      = rd_q;
    assign out_is_load = is_load_q;

`ifdef EX_OPERAND_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (in_valid && !in_ready) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
